multdiv_ctrl: RTL and testbench
===============================

# multdiv_ctrl

Multi-cycle signed multiply/divide sequencer for the processor's MULT/DIV unit. It latches operands on a start pulse and steps a 64-bit product/remainder register through 32 iterations: Booth radix-2 for multiply, restoring on magnitudes for divide. It then applies sign/overflow fix-up and presents a 32-bit result with a one-cycle ready strobe to the pipeline stall logic.

## Interface
- WIDTH, 32, operand/result width (only 32 is supported)
- CNT_W, 6, iteration counter width
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  asynchronous active-low reset; all state cleared while clr=0
- data_operandA  in  32  multiplicand / dividend (two's complement)
- data_operandB  in  32  multiplier / divisor (two's complement)
- ctrl_MULT  in  1  start-multiply pulse, sampled each edge
- ctrl_DIV  in  1  start-divide pulse, sampled each edge
- data_result  out  32  product low word / quotient
- data_exception  out  1  overflow or divide-by-zero flag
- data_resultRDY  out  1  one-cycle completion strobe
- busy  out  1  high in MULT_RUN, DIV_RUN, DIV_FIX

## Operation
- States: IDLE, MULT_RUN, DIV_RUN, DIV_FIX, DONE. Reset → IDLE. Reset values: product register, counter, data_result, data_exception, data_resultRDY and busy are all 0.
- Start: an edge with ctrl_MULT=1 latches A and B and enters MULT_RUN. An edge with ctrl_DIV=1 (and ctrl_MULT=0) latches the operands and enters DIV_RUN. If both are high, MULT wins.
- A start while busy aborts the current operation and restarts with the new operands. No ready strobe is issued for the aborted operation.
- MULT_RUN: product register = {32'b0, B}, plus a Booth bit. Each cycle, add, subtract or skip A on the upper half per the {P[0], booth} pair, then arithmetic-shift right 1. After 32 iterations → DONE.
- Multiply result = P[31:0]. data_exception=1 iff P[63:32] is not all copies of P[31]. The result is still the low word.
- DIV_RUN with B=0: skip iteration and go straight to DONE with result=0 and exception=1.
- DIV_RUN otherwise: remainder/quotient register = {32'b0, |A|}. Each cycle, shift left 1 and trial-subtract |B| from the upper half. If the difference is non-negative, keep it and set Q[0]=1. After 32 iterations → DIV_FIX.
- DIV_FIX: negate the quotient iff sign(A)≠sign(B). Division truncates toward zero. A=0x80000000 with B=0xFFFFFFFF gives result 0x80000000 and exception=1. → DONE.
- DONE: data_resultRDY=1 for exactly this cycle, then → IDLE. A start sampled in DONE is accepted normally; the strobe still occurs in that cycle.
- data_result and data_exception update only on entry to DONE. They hold until the next DONE or reset.

## Timing
- Cycle 0 is the cycle in which the start pulse is high. Latency is counted to the cycle in which data_resultRDY=1.
- MULT: 33 cycles.
- DIV, non-zero divisor: 34 cycles.
- DIV by zero: 2 cycles.
- Operand inputs are sampled only at the start edge. Later changes on them are ignored.
- The counter runs 0..31 and never wraps. The transition out of a RUN state happens on the edge where count=31.
- clr asserted mid-operation: outputs go to 0 immediately, state → IDLE, and no strobe follows.
- clr deasserted: the first start is accepted on the first rising edge with clr=1.

## Structure
- Shared package: state encoding constants (IDLE=0, MULT_RUN=1, DIV_RUN=2, DIV_FIX=3, DONE=4), WIDTH, ITER=32.
- One sub-module, multdiv_step: combinational single-iteration unit that takes the 64-bit register, the operand and mode, and returns the next register value. The FSM, counter and 64-bit register live in multdiv_ctrl.

## Test plan
- MULT 7 × 0xFFFFFFFD → data_result 0xFFFFFFEB, exception 0, RDY at cycle 33 only.
- MULT 0x00010000 × 0x00010000 → result 0x00000000, exception 1. MULT 0x80000000 × 0xFFFFFFFF → result 0x80000000, exception 1.
- DIV 0xFFFFFFF9 / 2 → result 0xFFFFFFFD (−3), exception 0, RDY at cycle 34. DIV 100 / 7 → 14.
- DIV 5 / 0 → result 0, exception 1, RDY at cycle 2.
- MULT 3×4 started, then ctrl_DIV with 20/4 at cycle 10 → a single RDY at cycle 44 with result 5. No strobe for the multiply.
- MULT started, clr=0 at cycle 15 for 2 cycles → all outputs 0 immediately, no RDY. A new MULT 2×2 afterwards → 4 after 33 cycles.

Source files
------------

// File: rtl/multdiv_ctrl_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
// Holds the FSM state encoding, datapath width and the iteration count.
package multdiv_ctrl_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITER  = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MULT_RUN = 3'd1,
        DIV_RUN  = 3'd2,
        DIV_FIX  = 3'd3,
        DONE     = 3'd4
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ('0 - v) : v;
    endfunction

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the shared 64-bit product/remainder register:
// Booth radix-2 add/sub + arithmetic shift, or restoring shift + trial subtract.
module multdiv_step
    import multdiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic               booth_i,
    input  op_e                mode_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               booth_o
);

    logic [WIDTH:0]       hi_ext;
    logic [WIDTH:0]       op_ext;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   shl;
    logic [WIDTH:0]       diff;

    always_comb begin
        acc_o   = acc_i;
        booth_o = booth_i;
        hi_ext  = {acc_i[2*WIDTH-1], acc_i[2*WIDTH-1:WIDTH]};
        op_ext  = {operand_i[WIDTH-1], operand_i};
        sum     = hi_ext;
        shl     = {acc_i[2*WIDTH-2:0], 1'b0};
        diff    = {1'b0, shl[2*WIDTH-1:WIDTH]} - {1'b0, operand_i};

        if (mode_i == OP_MUL) begin
            case ({acc_i[0], booth_i})
                2'b01:   sum = hi_ext + op_ext;
                2'b10:   sum = hi_ext - op_ext;
                default: sum = hi_ext;
            endcase
            // Sum kept at WIDTH+1 bits so the bit shifted in is the true sign.
            acc_o   = {sum, acc_i[WIDTH-1:1]};
            booth_o = acc_i[0];
        end else begin
            if (!diff[WIDTH]) begin
                acc_o = {diff[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
            end else begin
                acc_o = shl;
            end
        end
    end

endmodule

// File: rtl/multdiv_ctrl.sv
// Multi-cycle signed MULT/DIV sequencer: latches operands on a start pulse,
// iterates 32 times, fixes up sign/overflow and emits a one-cycle ready strobe.
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] p_q;
    logic [2*WIDTH-1:0] p_d;
    logic               booth_q;
    logic               booth_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   result_q;
    logic               exc_q;
    logic               rdy_q;
    logic               busy_q;

    op_e                mode;
    logic [WIDTH-1:0]   step_op;
    logic               mul_ovf;
    logic [WIDTH-1:0]   quot_fix;
    logic               div_ovf;

    assign mode    = (state_q == DIV_RUN) ? OP_DIV : OP_MUL;
    assign step_op = (mode == OP_DIV) ? mag(b_q) : a_q;

    multdiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc_i    (p_q),
        .operand_i(step_op),
        .booth_i  (booth_q),
        .mode_i   (mode),
        .acc_o    (p_d),
        .booth_o  (booth_d)
    );

    always_comb begin
        mul_ovf  = (p_d[2*WIDTH-1:WIDTH] != {WIDTH{p_d[WIDTH-1]}});
        quot_fix = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? ('0 - p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
        div_ovf  = (a_q == MOST_NEG) && (b_q == '1);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            booth_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            // A start in any state, DONE included, restarts the sequencer.
            if (ctrl_MULT) begin
                a_q     <= data_operandA;
                b_q     <= data_operandB;
                p_q     <= {{WIDTH{1'b0}}, data_operandB};
                booth_q <= 1'b0;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= MULT_RUN;
            end else if (ctrl_DIV) begin
                a_q     <= data_operandA;
                b_q     <= data_operandB;
                p_q     <= {{WIDTH{1'b0}}, mag(data_operandA)};
                booth_q <= 1'b0;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= DIV_RUN;
            end else begin
                case (state_q)
                    MULT_RUN: begin
                        p_q     <= p_d;
                        booth_q <= booth_d;
                        if (cnt_q == LAST_CNT) begin
                            cnt_q    <= '0;
                            result_q <= p_d[WIDTH-1:0];
                            exc_q    <= mul_ovf;
                            rdy_q    <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    DIV_RUN: begin
                        if (b_q == '0) begin
                            result_q <= '0;
                            exc_q    <= 1'b1;
                            rdy_q    <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= DONE;
                        end else begin
                            p_q <= p_d;
                            if (cnt_q == LAST_CNT) begin
                                cnt_q   <= '0;
                                state_q <= DIV_FIX;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    DIV_FIX: begin
                        result_q <= quot_fix;
                        exc_q    <= div_ovf;
                        rdy_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= DONE;
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed + random bench for multdiv_ctrl with a queued expected-result model.
// Cycle 0 is the cycle holding the start pulse; outputs are sampled on negedges.
module tb_multdiv_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        mul;
    logic        div;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        exc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    multdiv_ctrl #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .data_operandA (opa),
        .data_operandB (opb),
        .ctrl_MULT     (mul),
        .ctrl_DIV      (div),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push_model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                              input string tag);
        exp_t   e;
        longint p;
        int     q;
        e.tag = tag;
        if (is_mul) begin
            p     = longint'($signed(a)) * longint'($signed(b));
            e.res = p[31:0];
            e.exc = (p[63:32] != {32{p[31]}});
            e.lat = 33;
        end else if (b == 32'h0) begin
            e.res = 32'h0;
            e.exc = 1'b1;
            e.lat = 2;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
            e.lat = 34;
        end else begin
            q     = $signed(a) / $signed(b);
            e.res = q;
            e.exc = 1'b0;
            e.lat = 34;
        end
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge ending cycle 0 (sampling cycle 1).
    task automatic issue(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        mul = is_mul;
        div = !is_mul;
        opa = a;
        opb = b;
        @(negedge clk);
        mul = 1'b0;
        div = 1'b0;
        opa = $urandom;
        opb = $urandom;
        check32({tag, "/busy"}, {31'b0, busy}, 32'd1);
    endtask

    task automatic expect_done();
        exp_t e;
        int   seen = 0;
        e = sb.pop_front();
        for (int c = 1; c <= e.lat + 3; c++) begin
            if (data_resultRDY) begin
                seen = c;
                break;
            end
            @(negedge clk);
        end
        check32({e.tag, "/latency"}, seen, e.lat);
        if (seen != 0) begin
            check32({e.tag, "/result"}, data_result, e.res);
            check32({e.tag, "/exc"}, {31'b0, data_exception}, {31'b0, e.exc});
            check32({e.tag, "/busy_done"}, {31'b0, busy}, 32'd0);
            @(negedge clk);
            check32({e.tag, "/rdy_oneshot"}, {31'b0, data_resultRDY}, 32'd0);
            check32({e.tag, "/hold"}, data_result, e.res);
        end
    endtask

    task automatic run(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
        push_model(is_mul, a, b, tag);
        issue(is_mul, a, b, tag);
        expect_done();
    endtask

    initial begin
        logic        stray;
        logic [31:0] ra;
        logic [31:0] rb;

        mul = 1'b0;
        div = 1'b0;
        opa = '0;
        opb = '0;

        #1 clr = 1'b0;
        #2;
        check32("reset/result", data_result, 32'h0);
        check32("reset/exc", {31'b0, data_exception}, 32'd0);
        check32("reset/rdy", {31'b0, data_resultRDY}, 32'd0);
        check32("reset/busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        clr = 1'b1;

        run(1'b1, 32'd7,         32'hFFFF_FFFD, "mul_7x-3");
        run(1'b1, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "mul_min_x_m1");
        run(1'b0, 32'hFFFF_FFF9, 32'd2,         "div_m7_2");
        run(1'b0, 32'd100,       32'd7,         "div_100_7");
        run(1'b0, 32'd100,       32'hFFFF_FFF9, "div_100_m7");
        run(1'b0, 32'd5,         32'd0,         "div_by0");
        run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "mul_maxsq");

        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom_range(0, 1) ? $urandom : $urandom_range(1, 1000);
            run(i[0], ra, rb, $sformatf("rand%0d", i));
        end

        // Divide started at cycle 10 overrides an in-flight multiply.
        issue(1'b1, 32'd3, 32'd4, "abort_mul");
        stray = 1'b0;
        repeat (9) begin
            if (data_resultRDY) stray = 1'b1;
            @(negedge clk);
        end
        check32("abort/quiet", {31'b0, stray}, 32'd0);
        run(1'b0, 32'd20, 32'd4, "abort_div");

        // Reset mid-multiply clears outputs at once and suppresses the strobe.
        ra = $urandom;
        rb = $urandom;
        issue(1'b1, ra, rb, "clr_mul");
        repeat (14) @(negedge clk);
        clr = 1'b0;
        #1;
        check32("clr/result", data_result, 32'h0);
        check32("clr/exc", {31'b0, data_exception}, 32'd0);
        check32("clr/rdy", {31'b0, data_resultRDY}, 32'd0);
        check32("clr/busy", {31'b0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        stray = 1'b0;
        repeat (40) begin
            if (data_resultRDY || busy) stray = 1'b1;
            @(negedge clk);
        end
        check32("clr/quiet", {31'b0, stray}, 32'd0);
        run(1'b1, 32'd2, 32'd2, "post_clr_mul");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
